// File: rtl/matrix_keypad_scanner.sv
// Column-scanning keypad controller: debounced press/release, one key_valid per press.
// Press reported (DEBOUNCE-1) ticks + 1 clock after first sample; no backpressure. Repeat: `KEYPAD_REPEAT_EN.
module matrix_keypad_scanner #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE     = 4,
    parameter int REPEAT_DELAY = 100,
    parameter int REPEAT_RATE  = 25,
    localparam int CW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ROWS-1:0] KEY_R,
    output logic [COLS-1:0] KEY_C,
    output logic [CW-1:0]   key_code,
    output logic            key_valid,
    output logic            key_down
);

    localparam int DIVW = $clog2(SCAN_DIV);
    localparam int COLW = $clog2(COLS);
    localparam int ROWW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CNTW = $clog2(DEBOUNCE + 1);

    localparam logic [1:0] S_SCAN = 2'd0;
    localparam logic [1:0] S_DEB  = 2'd1;
    localparam logic [1:0] S_ACC  = 2'd2;
    localparam logic [1:0] S_HELD = 2'd3;

    if (ROWS < 1 || ROWS > 16 || COLS < 2 || COLS > 16 || SCAN_DIV < 4 ||
        DEBOUNCE < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
        $error("matrix_keypad_scanner: illegal parameter set");
    end

    logic [ROWS-1:0] r_meta_q, r_sync_q;
    logic [DIVW-1:0] div_q, div_d;
    logic [1:0]      state_q, state_d;
    logic [COLW-1:0] col_q, col_d, col_next;
    logic [ROWW-1:0] row_q, row_d, low_row;
    logic [ROWS-1:0] pat_q, pat_d;
    logic [CNTW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CW-1:0]   code_q, code_d;
    logic            valid_q, valid_d;
    logic            down_q, down_d;
    logic [COLS-1:0] kc_q, kc_d;
    logic            tick;
    logic            any_act;
    logic [ROWS-1:0] rs;

`ifdef KEYPAD_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rcnt_q, rcnt_d, rcnt_inc, rtarget;
    logic          rfirst_q, rfirst_d;
    logic          rstop_q, rstop_d;

    assign rcnt_inc = rcnt_q + RW'(1);
    assign rtarget  = rfirst_q ? RW'(REPEAT_DELAY) : RW'(REPEAT_RATE);
`endif

    assign rs       = r_sync_q;
    assign any_act  = ~&rs;
    assign tick     = (div_q == DIVW'(SCAN_DIV - 1));
    assign div_d    = tick ? '0 : div_q + DIVW'(1);
    assign col_next = (col_q == COLW'(COLS - 1)) ? '0 : col_q + COLW'(1);
    assign cnt_inc  = cnt_q + CNTW'(1);

    // Lowest-index active row wins when several rows are down in one column.
    always_comb begin
        low_row = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!rs[i]) begin
                low_row = ROWW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        valid_d = 1'b0;
        down_d  = down_q;
`ifdef KEYPAD_REPEAT_EN
        rcnt_d   = rcnt_q;
        rfirst_d = rfirst_q;
        rstop_d  = rstop_q;
`endif
        case (state_q)
            S_SCAN: begin
                if (tick) begin
                    if (any_act) begin
                        row_d   = low_row;
                        pat_d   = rs;
                        cnt_d   = CNTW'(1);
                        state_d = (DEBOUNCE > 1) ? S_DEB : S_ACC;
                    end else begin
                        col_d = col_next;
                    end
                end
            end
            S_DEB: begin
                if (tick) begin
                    if (rs == pat_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNTW'(DEBOUNCE)) begin
                            state_d = S_ACC;
                        end
                    end else begin
                        state_d = S_SCAN;
                    end
                end
            end
            S_ACC: begin
                code_d  = CW'(row_q) * CW'(COLS) + CW'(col_q);
                valid_d = 1'b1;
                down_d  = 1'b1;
                cnt_d   = '0;
                state_d = S_HELD;
`ifdef KEYPAD_REPEAT_EN
                rcnt_d   = '0;
                rfirst_d = 1'b1;
                rstop_d  = 1'b0;
`endif
            end
            default: begin
                if (tick) begin
                    if (!any_act) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNTW'(DEBOUNCE)) begin
                            down_d  = 1'b0;
                            col_d   = col_next;
                            state_d = S_SCAN;
                        end
                    end else begin
                        cnt_d = '0;
                    end
`ifdef KEYPAD_REPEAT_EN
                    // Any all-high tick ends repeating for this press, even if the key bounces back.
                    if (!any_act) begin
                        rstop_d = 1'b1;
                    end else if (!rstop_q) begin
                        rcnt_d = rcnt_inc;
                        if (rcnt_inc == rtarget) begin
                            valid_d  = 1'b1;
                            rcnt_d   = '0;
                            rfirst_d = 1'b0;
                        end
                    end
`endif
                end
            end
        endcase
    end

    // Column drive follows the next column so it is asserted for a whole tick before sampling.
    assign kc_d = ~(COLS'(1) << col_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta_q <= '1;
            r_sync_q <= '1;
            div_q    <= '0;
            state_q  <= S_SCAN;
            col_q    <= '0;
            row_q    <= '0;
            pat_q    <= '1;
            cnt_q    <= '0;
            code_q   <= '0;
            valid_q  <= 1'b0;
            down_q   <= 1'b0;
            kc_q     <= '1;
`ifdef KEYPAD_REPEAT_EN
            rcnt_q   <= '0;
            rfirst_q <= 1'b1;
            rstop_q  <= 1'b0;
`endif
        end else begin
            r_meta_q <= KEY_R;
            r_sync_q <= r_meta_q;
            div_q    <= div_d;
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            pat_q    <= pat_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            valid_q  <= valid_d;
            down_q   <= down_d;
            kc_q     <= kc_d;
`ifdef KEYPAD_REPEAT_EN
            rcnt_q   <= rcnt_d;
            rfirst_q <= rfirst_d;
            rstop_q  <= rstop_d;
`endif
        end
    end

    assign KEY_C     = kc_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_down  = down_q;

endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// Directed bench for matrix_keypad_scanner with a behavioural 4x4 switch matrix.
module tb_matrix_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  KEY_R;
    logic [3:0]  KEY_C;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] pressed = '0;

    int errors = 0;
    int checks = 0;
    int valid_total = 0;
    int consec = 0;
    logic prev_valid = 1'b0;

`ifdef KEYPAD_REPEAT_EN
    localparam int EXP_REP = 5;
`else
    localparam int EXP_REP = 1;
`endif

    matrix_keypad_scanner #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3), .REPEAT_DELAY(5), .REPEAT_RATE(2)
    ) dut (
        .clk(clk), .rst(rst), .KEY_R(KEY_R), .KEY_C(KEY_C),
        .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
    );

    always #5 clk = ~clk;

    // Switch matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        KEY_R = '1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && KEY_C[c] === 1'b0) KEY_R[r] = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (key_valid === 1'b1) begin
            valid_total <= valid_total + 1;
            if (prev_valid) consec <= consec + 1;
        end
        prev_valid <= (key_valid === 1'b1);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_down_low(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (key_down === 1'b0) begin ok = 1'b1; break; end
        end
    endtask

    // Returns at the first negedge where KEY_C has just switched to pat.
    task automatic wait_col_enter(input logic [3:0] pat, input int budget, output bit ok);
        int  n = 0;
        bit  left = 1'b0;
        while (KEY_C === pat && n < budget) begin @(negedge clk); n++; end
        if (KEY_C !== pat) left = 1'b1;
        while (KEY_C !== pat && n < budget) begin @(negedge clk); n++; end
        ok = left && (KEY_C === pat);
    endtask

    task automatic test_reset();
        bit ok;
        logic [3:0] rot [3];
        rot[0] = 4'b1011; rot[1] = 4'b0111; rot[2] = 4'b1110;
        rst = 1'b1; pressed = '0;
        repeat (3) @(negedge clk);
        checks++; if (KEY_C !== 4'hF) begin errors++; $display("FAIL reset_kc: got %b want 1111", KEY_C); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", key_valid); end
        checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL reset_down: got %b want 0", key_down); end
        checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", key_code); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (KEY_C !== 4'b1110) begin errors++; $display("FAIL first_col: got %b want 1110", KEY_C); end
        wait_col_enter(4'b1101, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rot_col1: got %b want 1101", KEY_C); end
        for (int i = 0; i < 3; i++) begin
            repeat (4) @(negedge clk);
            checks++; if (KEY_C !== rot[i]) begin errors++; $display("FAIL rotate_%0d: got %b want %b", i, KEY_C, rot[i]); end
        end
    endtask

    task automatic test_clean_press();
        bit ok;
        int base = valid_total;
        pressed[2*4+1] = 1'b1;
        wait_valid(80, ok);
        checks++; if (!ok) begin errors++; $display("FAIL clean_valid: no strobe, want one"); end
        checks++; if (key_code !== 4'd9) begin errors++; $display("FAIL clean_code: got %0d want 9", key_code); end
        checks++; if (key_down !== 1'b1) begin errors++; $display("FAIL clean_down: got %b want 1", key_down); end
        repeat (12) @(negedge clk);
        checks++; if (key_down !== 1'b1) begin errors++; $display("FAIL clean_hold: got %b want 1", key_down); end
        checks++; if (valid_total - base !== 1) begin errors++; $display("FAIL clean_count: got %0d want 1", valid_total - base); end
        pressed[2*4+1] = 1'b0;
        repeat (8) @(negedge clk);
        checks++; if (key_down !== 1'b1) begin errors++; $display("FAIL release_early: got %b want 1", key_down); end
        wait_down_low(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL release_timeout: key_down got %b want 0", key_down); end
        checks++; if (KEY_C !== 4'b1011) begin errors++; $display("FAIL release_col: got %b want 1011", KEY_C); end
        checks++; if (valid_total - base !== 1) begin errors++; $display("FAIL release_count: got %0d want 1", valid_total - base); end
    endtask

    task automatic test_bounce();
        bit ok;
        int base;
        wait_col_enter(4'b1011, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bounce_sync: got %b want 1011", KEY_C); end
        base = valid_total;
        pressed[0*4+2] = 1'b1;
        repeat (5) @(negedge clk);
        pressed[0*4+2] = 1'b0;
        repeat (3) @(negedge clk);
        pressed[0*4+2] = 1'b1;
        @(negedge clk);
        checks++; if (KEY_C !== 4'b1011) begin errors++; $display("FAIL bounce_col: got %b want 1011", KEY_C); end
        checks++; if (valid_total - base !== 0) begin errors++; $display("FAIL bounce_early: got %0d want 0", valid_total - base); end
        repeat (11) @(negedge clk);
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL bounce_pre: got %b want 0", key_valid); end
        @(negedge clk);
        checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL bounce_accept: got %b want 1", key_valid); end
        checks++; if (key_code !== 4'd2) begin errors++; $display("FAIL bounce_code: got %0d want 2", key_code); end
        pressed = '0;
        wait_down_low(40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bounce_release: key_down got %b want 0", key_down); end
        checks++; if (valid_total - base !== 1) begin errors++; $display("FAIL bounce_count: got %0d want 1", valid_total - base); end
    endtask

    task automatic test_two_keys();
        bit ok;
        int base = valid_total;
        pressed[1*4+0] = 1'b1;
        pressed[3*4+0] = 1'b1;
        wait_valid(80, ok);
        checks++; if (!ok) begin errors++; $display("FAIL two_valid: no strobe, want one"); end
        checks++; if (key_code !== 4'd4) begin errors++; $display("FAIL two_code: got %0d want 4", key_code); end
        pressed[1*4+3] = 1'b1;
        repeat (14) @(negedge clk);
        checks++; if (KEY_C !== 4'b1110) begin errors++; $display("FAIL two_col_held: got %b want 1110", KEY_C); end
        checks++; if (key_code !== 4'd4) begin errors++; $display("FAIL two_code_hold: got %0d want 4", key_code); end
        checks++; if (valid_total - base !== 1) begin errors++; $display("FAIL two_count: got %0d want 1", valid_total - base); end
        pressed = '0;
        wait_down_low(40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL two_release: key_down got %b want 0", key_down); end
        repeat (2) @(negedge clk);
        checks++; if (valid_total - base !== 1) begin errors++; $display("FAIL two_final: got %0d want 1", valid_total - base); end
    endtask

    task automatic test_reset_mid_held();
        bit ok;
        int base = valid_total;
        pressed[0*4+1] = 1'b1;
        wait_valid(80, ok);
        checks++; if (!ok) begin errors++; $display("FAIL midrst_valid: no strobe, want one"); end
        repeat (3) @(negedge clk);
        checks++; if (key_down !== 1'b1) begin errors++; $display("FAIL midrst_down: got %b want 1", key_down); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL midrst_drop: got %b want 0", key_down); end
        checks++; if (KEY_C !== 4'hF) begin errors++; $display("FAIL midrst_kc: got %b want 1111", KEY_C); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL midrst_strobe: got %b want 0", key_valid); end
        @(negedge clk);
        pressed = '0;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (KEY_C !== 4'b1110) begin errors++; $display("FAIL midrst_col0: got %b want 1110", KEY_C); end
        checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL midrst_code: got %0d want 0", key_code); end
        checks++; if (valid_total - base !== 1) begin errors++; $display("FAIL midrst_count: got %0d want 1", valid_total - base); end
    endtask

    task automatic test_repeat();
        bit ok;
        int base = valid_total;
        pressed[3*4+3] = 1'b1;
        wait_valid(80, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rep_valid: no strobe, want one"); end
        repeat (47) @(negedge clk);
        checks++; if (key_code !== 4'd15) begin errors++; $display("FAIL rep_code: got %0d want 15", key_code); end
        checks++; if (valid_total - base !== EXP_REP) begin errors++; $display("FAIL rep_count: got %0d want %0d", valid_total - base, EXP_REP); end
        pressed = '0;
        wait_down_low(40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rep_release: key_down got %b want 0", key_down); end
        checks++; if (valid_total - base !== EXP_REP) begin errors++; $display("FAIL rep_stop: got %0d want %0d", valid_total - base, EXP_REP); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_two_keys();
        test_reset_mid_held();
        test_repeat();
        checks++; if (consec !== 0) begin errors++; $display("FAIL back_to_back: got %0d consecutive strobes want 0", consec); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
